// File: rtl/multi_seq_detector_if.sv
// Bundles the sample/control inputs and the hit outputs of multi_seq_detector.
// The stimulus side takes the master modport. The detector takes the slave modport.
interface multi_seq_detector_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             X;
  logic             clr_cnt;
  logic             Z1;
  logic             Z2;
  logic             armed2;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;

  modport master (
    output en, X, clr_cnt,
    input  Z1, Z2, armed2, cnt1, cnt2
  );

  modport slave (
    input  en, X, clr_cnt,
    output Z1, Z2, armed2, cnt1, cnt2
  );
endinterface

// File: rtl/multi_seq_detector.sv
// Two-channel serial pattern detector sharing one history shift register.
// Each channel has a saturating fill count, a registered hit pulse and a saturating hit counter.
module multi_seq_detector #(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PAT1    = 3'b010,
  parameter logic [PAT_LEN-1:0] PAT2    = 3'b100,
  parameter bit                 OVERLAP = 1'b1,
  parameter bit                 CHAIN   = 1'b0,
  parameter int                 CNT_W   = 8
) (
  input logic                clk,
  input logic                reset,
  multi_seq_detector_if.slave bus
);
  localparam int              FW        = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]   FILL_FULL = FW'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {ARM_WAIT, ARM_LIVE} arm_state_e;

  arm_state_e         arm_q, arm_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic               armed2;
  logic [1:0]         hit_vec;
  logic [1:0]         z_vec;
  logic [CNT_W-1:0]   cnt_vec [2];

  assign hist_d = bus.en ? {hist_q[PAT_LEN-2:0], bus.X} : hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Channel 2 arming: only meaningful when chaining, otherwise it starts and stays live.
  always_comb begin
    arm_d = arm_q;
    case (arm_q)
      ARM_WAIT: if (hit_vec[0]) arm_d = ARM_LIVE;
      ARM_LIVE: arm_d = ARM_LIVE;
      default:  arm_d = ARM_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q <= CHAIN ? ARM_WAIT : ARM_LIVE;
    end else begin
      arm_q <= arm_d;
    end
  end

  assign armed2 = (arm_q == ARM_LIVE);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    localparam logic [PAT_LEN-1:0] PAT = (gi == 0) ? PAT1 : PAT2;

    logic [FW-1:0]    fill_q, fill_d, fill_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q;
    logic             hit;
    logic             eligible;

    // armed2 is sampled from its register, so a same-edge channel-1 hit cannot enable channel 2.
    assign eligible = (gi == 0) ? 1'b1 : armed2;

    always_comb begin
      fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      fill_d   = fill_q;
      hit      = 1'b0;
      if (bus.en) begin
        hit    = (fill_inc == FILL_FULL) && (hist_d == PAT) && eligible;
        fill_d = (hit && !OVERLAP) ? '0 : fill_inc;
      end
      cnt_d = cnt_q;
      if (bus.clr_cnt) begin
        cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        fill_q <= '0;
        cnt_q  <= '0;
        z_q    <= 1'b0;
      end else begin
        fill_q <= fill_d;
        cnt_q  <= cnt_d;
        z_q    <= hit;
      end
    end

    assign hit_vec[gi] = hit;
    assign z_vec[gi]   = z_q;
    assign cnt_vec[gi] = cnt_q;
  end

  assign bus.Z1     = z_vec[0];
  assign bus.Z2     = z_vec[1];
  assign bus.armed2 = armed2;
  assign bus.cnt1   = cnt_vec[0];
  assign bus.cnt2   = cnt_vec[1];
endmodule

// File: tb/tb_multi_seq_detector.sv
// Drives one stream into four detector variants (default, non-overlap, chained, 2-bit counters)
// and checks every cycle against a queue-based model, plus literal expectations per scenario.
module tb_multi_seq_detector;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic X = 1'b0;
  logic clr_cnt = 1'b0;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  multi_seq_detector_if #(.CNT_W(8)) if_def ();
  multi_seq_detector_if #(.CNT_W(8)) if_nov ();
  multi_seq_detector_if #(.CNT_W(8)) if_chn ();
  multi_seq_detector_if #(.CNT_W(2)) if_c2 ();

  assign if_def.en = en;  assign if_def.X = X;  assign if_def.clr_cnt = clr_cnt;
  assign if_nov.en = en;  assign if_nov.X = X;  assign if_nov.clr_cnt = clr_cnt;
  assign if_chn.en = en;  assign if_chn.X = X;  assign if_chn.clr_cnt = clr_cnt;
  assign if_c2.en  = en;  assign if_c2.X  = X;  assign if_c2.clr_cnt  = clr_cnt;

  multi_seq_detector #(.PAT_LEN(3), .PAT1(3'b010), .PAT2(3'b100), .OVERLAP(1'b1), .CHAIN(1'b0), .CNT_W(8))
    u_def (.clk(clk), .reset(reset), .bus(if_def));
  multi_seq_detector #(.PAT_LEN(3), .PAT1(3'b010), .PAT2(3'b100), .OVERLAP(1'b0), .CHAIN(1'b0), .CNT_W(8))
    u_nov (.clk(clk), .reset(reset), .bus(if_nov));
  multi_seq_detector #(.PAT_LEN(3), .PAT1(3'b010), .PAT2(3'b100), .OVERLAP(1'b1), .CHAIN(1'b1), .CNT_W(8))
    u_chn (.clk(clk), .reset(reset), .bus(if_chn));
  multi_seq_detector #(.PAT_LEN(3), .PAT1(3'b010), .PAT2(3'b100), .OVERLAP(1'b1), .CHAIN(1'b0), .CNT_W(2))
    u_c2 (.clk(clk), .reset(reset), .bus(if_c2));

  logic       z1_a [4];
  logic       z2_a [4];
  logic       arm_a [4];
  logic [7:0] c1_a [4];
  logic [7:0] c2_a [4];

  assign z1_a[0] = if_def.Z1; assign z2_a[0] = if_def.Z2; assign arm_a[0] = if_def.armed2;
  assign z1_a[1] = if_nov.Z1; assign z2_a[1] = if_nov.Z2; assign arm_a[1] = if_nov.armed2;
  assign z1_a[2] = if_chn.Z1; assign z2_a[2] = if_chn.Z2; assign arm_a[2] = if_chn.armed2;
  assign z1_a[3] = if_c2.Z1;  assign z2_a[3] = if_c2.Z2;  assign arm_a[3] = if_c2.armed2;
  assign c1_a[0] = if_def.cnt1; assign c2_a[0] = if_def.cnt2;
  assign c1_a[1] = if_nov.cnt1; assign c2_a[1] = if_nov.cnt2;
  assign c1_a[2] = if_chn.cnt1; assign c2_a[2] = if_chn.cnt2;
  assign c1_a[3] = {6'b0, if_c2.cnt1}; assign c2_a[3] = {6'b0, if_c2.cnt2};

  // Per-variant configuration for the model.
  bit ov_c [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit ch_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int cw_c [4] = '{8, 8, 8, 2};

  // Model: every bit sampled since reset, plus per-channel bits-since-restart counts.
  bit samp [$];
  int mf1 [4], mf2 [4], mc1 [4], mc2 [4];
  bit mz1 [4], mz2 [4], marm [4];

  always @(posedge clk) begin
    int tv, n, f1, f2, cmax;
    bit h1, h2;
    if (reset) begin
      samp.delete();
      for (int i = 0; i < 4; i++) begin
        mf1[i] = 0; mf2[i] = 0; mc1[i] = 0; mc2[i] = 0;
        mz1[i] = 0; mz2[i] = 0; marm[i] = !ch_c[i];
      end
    end else begin
      if (en) samp.push_back(X);
      n = samp.size();
      tv = (n >= 3) ? (4 * samp[n-3] + 2 * samp[n-2] + samp[n-1]) : -1;
      for (int i = 0; i < 4; i++) begin
        h1 = 0; h2 = 0;
        if (en) begin
          f1 = (mf1[i] + 1 > 3) ? 3 : mf1[i] + 1;
          f2 = (mf2[i] + 1 > 3) ? 3 : mf2[i] + 1;
          h1 = (f1 == 3) && (tv == 2);
          h2 = (f2 == 3) && (tv == 4) && marm[i];
          mf1[i] = (h1 && !ov_c[i]) ? 0 : f1;
          mf2[i] = (h2 && !ov_c[i]) ? 0 : f2;
          if (h1) marm[i] = 1;
        end
        mz1[i] = h1; mz2[i] = h2;
        cmax = (1 << cw_c[i]) - 1;
        if (clr_cnt) begin
          mc1[i] = 0; mc2[i] = 0;
        end else begin
          if (h1 && mc1[i] < cmax) mc1[i] = mc1[i] + 1;
          if (h2 && mc2[i] < cmax) mc2[i] = mc2[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("z1[%0d]", i), 32'(z1_a[i]), 32'(mz1[i]));
        chk($sformatf("z2[%0d]", i), 32'(z2_a[i]), 32'(mz2[i]));
        chk($sformatf("armed2[%0d]", i), 32'(arm_a[i]), 32'(marm[i]));
        chk($sformatf("cnt1[%0d]", i), 32'(c1_a[i]), 32'(mc1[i]));
        chk($sformatf("cnt2[%0d]", i), 32'(c2_a[i]), 32'(mc2[i]));
      end
    end
  end

  task automatic step(input bit e, input bit x, input bit c);
    en = e; X = x; clr_cnt = c;
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t rst=%0b en=%0b X=%0b clr=%0b | Z1=%0b%0b%0b%0b Z2=%0b%0b%0b%0b cnt1=%0d cnt2=%0d",
             $time, reset, e, x, c, z1_a[0], z1_a[1], z1_a[2], z1_a[3],
             z2_a[0], z2_a[1], z2_a[2], z2_a[3], c1_a[0], c2_a[0]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
  endtask

  // S = 0,0,1,0,1,0,0,1,0,0,1,0,1,0 with bit b of s_bits holding S[b].
  logic [13:0] s_bits = 14'h1494;
  logic [13:0] zm1 [4];
  logic [13:0] zm2 [4];

  task automatic feed_s(input bit gap);
    for (int b = 0; b < 14; b++) begin
      if (gap && b == 3) begin
        for (int g = 0; g < 4; g++) begin
          step(1'b0, 1'b1, 1'b0);
          chk("gap_z1", 32'(z1_a[0]), 32'd0);
          chk("gap_z2", 32'(z2_a[0]), 32'd0);
        end
      end
      step(1'b1, s_bits[b], 1'b0);
      for (int i = 0; i < 4; i++) begin
        zm1[i][b] = z1_a[i];
        zm2[i][b] = z2_a[i];
      end
    end
  endtask

  initial begin
    logic [3:0] t3;
    // Reset state with junk on the inputs.
    do_reset();
    chk_on = 1'b1;
    chk("rst_z1", 32'(z1_a[0]), 32'd0);
    chk("rst_cnt1", 32'(c1_a[0]), 32'd0);
    chk("rst_armed2_def", 32'(arm_a[0]), 32'd1);
    chk("rst_armed2_chn", 32'(arm_a[2]), 32'd0);

    // Stream S: overlapping and non-overlapping variants.
    feed_s(1'b0);
    chk("t1_z1_mask", 32'(zm1[0]), 32'h2928);
    chk("t1_z2_mask", 32'(zm2[0]), 32'h0240);
    chk("t1_cnt1", 32'(c1_a[0]), 32'd5);
    chk("t1_cnt2", 32'(c2_a[0]), 32'd2);
    chk("t2_z1_mask", 32'(zm1[1]), 32'h0908);
    chk("t2_z2_mask", 32'(zm2[1]), 32'h0240);
    chk("t2_cnt1", 32'(c1_a[1]), 32'd3);
    chk("t2_cnt2", 32'(c2_a[1]), 32'd2);

    // Chained: 1,0,0,0,1,0,0. Window 100 after bit 2 is ignored; 010 completes at bit 5.
    do_reset();
    t3 = 4'b0;
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    chk("t3_unarmed_z2", 32'(z2_a[2]), 32'd0);
    chk("t3_unarmed", 32'(arm_a[2]), 32'd0);
    chk("t3_free_z2_def", 32'(z2_a[0]), 32'd1);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
    chk("t3_z1", 32'(z1_a[2]), 32'd1);
    chk("t3_armed_after_z1", 32'(arm_a[2]), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("t3_z2", 32'(z2_a[2]), 32'd1);
    chk("t3_cnt2", 32'(c2_a[2]), 32'd1);

    // 2-bit counter saturation: 0,1 repeated six times.
    do_reset();
    for (int b = 0; b < 12; b++) begin
      step(1'b1, b[0], 1'b0);
      if (b == 2 || b == 4 || b == 6) chk("t4_cnt_ramp", 32'(c1_a[3]), 32'(b / 2));
    end
    chk("t4_cnt_sat", 32'(c1_a[3]), 32'd3);
    chk("t4_cnt_wide", 32'(c1_a[0]), 32'd5);

    // Enable gap between bits 2 and 3 of S.
    do_reset();
    feed_s(1'b1);
    chk("t5_z1_mask", 32'(zm1[0]), 32'h2928);
    chk("t5_z2_mask", 32'(zm2[0]), 32'h0240);
    chk("t5_cnt1", 32'(c1_a[0]), 32'd5);

    // Mid-pattern reset, then clr_cnt coinciding with a hit.
    do_reset();
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
    chk("t6_no_z1_refill", 32'(z1_a[0]), 32'd0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1);
    chk("t6_clr_z1", 32'(z1_a[0]), 32'd1);
    chk("t6_clr_cnt1", 32'(c1_a[0]), 32'd0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
    chk("t6_cnt_resume", 32'(c1_a[0]), 32'd1);

    step(1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end
endmodule
